// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through synchronous FIFO placed between the
// host and the UART transmitter. It can also serve as the RX-side FIFO.
// The pointers carry one extra wrap bit, so equal pointers mean empty and
// pointers that differ only in the wrap bit mean full. The empty, full and
// count outputs are registered, and they are computed from the next-pointer
// values. As a result there is no combinational path from i_wr_en or i_rd_en
// to any output.
module uart_tx_fifo #(
    parameter int DataLength = 8,
    parameter int Depth      = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clr,
    input  logic                     i_wr_en,
    input  logic [DataLength-1:0]    i_wr_data,
    output logic                     o_full,
    input  logic                     i_rd_en,
    output logic [DataLength-1:0]    o_rd_data,
    output logic                     o_empty,
    output logic [$clog2(Depth):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int AddrW = $clog2(Depth);
    localparam int PtrW  = AddrW + 1;

    logic [DataLength-1:0] r_mem [Depth];
    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;
    logic [PtrW-1:0]       r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_push;
    logic                  w_pop;
    logic [PtrW-1:0]       w_wr_ptr_nxt;
    logic [PtrW-1:0]       w_rd_ptr_nxt;

    // Accept decisions use the registered flags from before the edge.
    // A flush overrides both requests.
    assign w_push = i_wr_en & ~r_full  & ~i_clr;
    assign w_pop  = i_rd_en & ~r_empty & ~i_clr;

    // Next pointer values. Natural overflow of PtrW bits gives the mod 2*Depth wrap.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr + PtrW'(w_push);
        w_rd_ptr_nxt = r_rd_ptr + PtrW'(w_pop);
        if (i_clr) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end
    end

    // Pointers and status flags. Empty, full and count are derived from the next pointers.
    // NOTE: state registers use non-blocking assignments, so every flop samples
    // the pre-edge values of its inputs regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_wr_ptr_nxt - w_rd_ptr_nxt;
            r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_full   <= (w_wr_ptr_nxt[AddrW-1:0] == w_rd_ptr_nxt[AddrW-1:0]) &&
                        (w_wr_ptr_nxt[AddrW]     != w_rd_ptr_nxt[AddrW]);
        end
    end

    // Sticky error flags. Only reset or a flush clears them, and they never block traffic.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_wr_en && r_full)  r_overflow  <= 1'b1;
            if (i_rd_en && r_empty) r_underflow <= 1'b1;
        end
    end

    // Storage array. Only an accepted push writes to it.
    // NOTE: the array is reset explicitly so that o_rd_data reads 0 out of
    // reset. This costs a reset net on every storage flop, so it is done only
    // because the read port is observable while the FIFO is empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr[AddrW-1:0]] <= i_wr_data;
        end
    end

    // FWFT read port. The head word is always presented from registered state only.
    assign o_rd_data   = r_mem[r_rd_ptr[AddrW-1:0]];
    assign o_empty     = r_empty;
    assign o_full      = r_full;
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. A queue-based reference model tracks
// the expected contents and the sticky flags. Each scenario task drives its
// stimulus and compares the DUT outputs against the model inline.
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_clr;
    logic          i_wr_en;
    logic [DW-1:0] i_wr_data;
    logic          o_full;
    logic          i_rd_en;
    logic [DW-1:0] o_rd_data;
    logic          o_empty;
    logic [CW-1:0] o_count;
    logic          o_overflow;
    logic          o_underflow;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [DW-1:0] q[$];
    logic          m_ovf;
    logic          m_unf;

    uart_tx_fifo #(.DataLength(DW), .Depth(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (i_clr),
        .i_wr_en     (i_wr_en),
        .i_wr_data   (i_wr_data),
        .o_full      (o_full),
        .i_rd_en     (i_rd_en),
        .o_rd_data   (o_rd_data),
        .o_empty     (o_empty),
        .o_count     (o_count),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural model of one clock edge. The accept rules use the occupancy before the edge.
    task automatic model_edge(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (clr) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (wr && was_full)  m_ovf = 1'b1;
            if (rd && was_empty) m_unf = 1'b1;
            if (rd && !was_empty) void'(q.pop_front());
            if (wr && !was_full)  q.push_back(d);
        end
    endtask

    // Apply one cycle of inputs, pass one rising edge, and leave the outputs settled (#1 after the edge).
    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
        i_wr_en   = wr;
        i_wr_data = d;
        i_rd_en   = rd;
        i_clr     = clr;
        @(posedge i_clk);
        #1;
        model_edge(wr, d, rd, clr);
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
        i_clr   = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_clr = 1'b0; i_wr_en = 1'b0; i_rd_en = 1'b0; i_wr_data = '0;
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        repeat (2) @(posedge i_clk);
        #3;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (o_count !== '0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", o_count); end
        n_checks++; if (o_empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b want 1", o_empty); end
        n_checks++; if (o_full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b want 0", o_full); end
        n_checks++; if (o_overflow !== 1'b0 || o_underflow !== 1'b0) begin
            n_errors++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0/0", o_overflow, o_underflow); end
        n_checks++; if (o_rd_data !== '0) begin n_errors++; $display("FAIL reset_rd_data: got %h want 00", o_rd_data); end
    endtask

    task automatic test_push_latency();
        i_wr_en = 1'b1; i_wr_data = 8'hA5;
        #2;
        n_checks++; if (o_empty !== 1'b1) begin n_errors++; $display("FAIL latency_empty_t0: got %b want 1", o_empty); end
        @(posedge i_clk);
        #1;
        model_edge(1'b1, 8'hA5, 1'b0, 1'b0);
        i_wr_en = 1'b0;
        n_checks++; if (o_empty !== 1'b0) begin n_errors++; $display("FAIL latency_empty_t1: got %b want 0", o_empty); end
        n_checks++; if (o_rd_data !== 8'hA5) begin n_errors++; $display("FAIL latency_data: got %h want a5", o_rd_data); end
        n_checks++; if (o_count !== CW'(1)) begin n_errors++; $display("FAIL latency_count: got %0d want 1", o_count); end
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (o_empty !== 1'b1) begin n_errors++; $display("FAIL latency_pop_empty: got %b want 1", o_empty); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (o_full !== 1'b0) begin n_errors++; $display("FAIL fill_full_early[%0d]: got %b want 0", i, o_full); end
            step(1'b1, DW'(i), 1'b0, 1'b0);
            n_checks++; if (o_count !== CW'(i + 1)) begin n_errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, o_count, i + 1); end
        end
        n_checks++; if (o_full !== 1'b1) begin n_errors++; $display("FAIL fill_full: got %b want 1", o_full); end
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        n_checks++; if (o_overflow !== 1'b1) begin n_errors++; $display("FAIL fill_overflow: got %b want 1", o_overflow); end
        n_checks++; if (o_rd_data !== 8'h00) begin n_errors++; $display("FAIL fill_head: got %h want 00", o_rd_data); end
        n_checks++; if (o_count !== CW'(DEPTH)) begin n_errors++; $display("FAIL fill_count_after_ovf: got %0d want %0d", o_count, DEPTH); end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (o_rd_data !== DW'(i)) begin n_errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, o_rd_data, DW'(i)); end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        n_checks++; if (o_empty !== 1'b1) begin n_errors++; $display("FAIL drain_empty: got %b want 1", o_empty); end
        n_checks++; if (o_underflow !== 1'b0) begin n_errors++; $display("FAIL drain_unf_early: got %b want 0", o_underflow); end
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (o_underflow !== 1'b1) begin n_errors++; $display("FAIL drain_underflow: got %b want 1", o_underflow); end
        n_checks++; if (o_count !== '0) begin n_errors++; $display("FAIL drain_count: got %0d want 0", o_count); end
        n_checks++; if (o_overflow !== 1'b1) begin n_errors++; $display("FAIL drain_ovf_sticky: got %b want 1", o_overflow); end
    endtask

    task automatic test_simultaneous();
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        n_checks++; if (o_count !== CW'(DEPTH - 1)) begin n_errors++; $display("FAIL simul_full_count: got %0d want %0d", o_count, DEPTH - 1); end
        n_checks++; if (o_overflow !== 1'b1) begin n_errors++; $display("FAIL simul_full_ovf: got %b want 1", o_overflow); end
        n_checks++; if (o_rd_data !== 8'h01) begin n_errors++; $display("FAIL simul_full_head: got %h want 01", o_rd_data); end
        // drain to confirm 0x55 was dropped: the tail must be 0x0F
        for (int i = 1; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (o_empty !== 1'b1) begin n_errors++; $display("FAIL simul_full_drop: got empty=%b want 1", o_empty); end
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 8'h66, 1'b1, 1'b0);
        n_checks++; if (o_count !== CW'(1)) begin n_errors++; $display("FAIL simul_empty_count: got %0d want 1", o_count); end
        n_checks++; if (o_underflow !== 1'b1) begin n_errors++; $display("FAIL simul_empty_unf: got %b want 1", o_underflow); end
        n_checks++; if (o_rd_data !== 8'h66) begin n_errors++; $display("FAIL simul_empty_data: got %h want 66", o_rd_data); end
        step(1'b1, 8'h77, 1'b1, 1'b0);
        n_checks++; if (o_empty !== 1'b0 || o_rd_data !== 8'h77) begin
            n_errors++; $display("FAIL simul_one_swap: got empty=%b data=%h want 0/77", o_empty, o_rd_data); end
        n_checks++; if (o_count !== CW'(1)) begin n_errors++; $display("FAIL simul_one_count: got %0d want 1", o_count); end
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_random_stream();
        int pushed = 0;
        int cyc    = 0;
        int wr_pct;
        int rd_pct;
        logic          wr;
        logic          rd;
        logic [DW-1:0] d;
        while (pushed < 100 && cyc < 2000) begin
            // alternate fill-heavy and drain-heavy phases so both full and empty boundaries are hit
            wr_pct = ((cyc / 40) % 2 == 0) ? 80 : 30;
            rd_pct = ((cyc / 40) % 2 == 0) ? 30 : 80;
            wr = ($urandom_range(0, 99) < wr_pct);
            rd = ($urandom_range(0, 99) < rd_pct);
            d  = DW'($urandom);
            if (wr && q.size() < DEPTH) pushed++;
            step(wr, d, rd, 1'b0);
            cyc++;
            n_checks++; if (o_count !== CW'(q.size())) begin n_errors++; $display("FAIL rand_count@%0d: got %0d want %0d", cyc, o_count, q.size()); end
            n_checks++; if (o_empty !== (q.size() == 0) || o_full !== (q.size() == DEPTH)) begin
                n_errors++; $display("FAIL rand_flags@%0d: got e=%b f=%b want e=%b f=%b", cyc, o_empty, o_full, q.size() == 0, q.size() == DEPTH); end
            n_checks++; if (o_overflow !== m_ovf || o_underflow !== m_unf) begin
                n_errors++; $display("FAIL rand_err@%0d: got ovf=%b unf=%b want %b/%b", cyc, o_overflow, o_underflow, m_ovf, m_unf); end
            if (q.size() != 0) begin
                n_checks++; if (o_rd_data !== q[0]) begin n_errors++; $display("FAIL rand_head@%0d: got %h want %h", cyc, o_rd_data, q[0]); end
            end
        end
        n_checks++; if (pushed < 100) begin n_errors++; $display("FAIL rand_budget: pushed %0d want 100", pushed); end
        while (q.size() != 0 && cyc < 3000) begin
            n_checks++; if (o_rd_data !== q[0]) begin n_errors++; $display("FAIL rand_drain@%0d: got %h want %h", cyc, o_rd_data, q[0]); end
            step(1'b0, '0, 1'b1, 1'b0);
            cyc++;
        end
        n_checks++; if (o_empty !== 1'b1) begin n_errors++; $display("FAIL rand_final_empty: got %b want 1", o_empty); end
    endtask

    task automatic test_clear();
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
        n_checks++; if (o_count !== CW'(5) || o_underflow !== 1'b1) begin
            n_errors++; $display("FAIL clr_setup: got count=%0d unf=%b want 5/1", o_count, o_underflow); end
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        n_checks++; if (o_empty !== 1'b1) begin n_errors++; $display("FAIL clr_empty: got %b want 1", o_empty); end
        n_checks++; if (o_count !== '0) begin n_errors++; $display("FAIL clr_count: got %0d want 0", o_count); end
        n_checks++; if (o_overflow !== 1'b0 || o_underflow !== 1'b0 || o_full !== 1'b0) begin
            n_errors++; $display("FAIL clr_flags: got ovf=%b unf=%b full=%b want 0/0/0", o_overflow, o_underflow, o_full); end
        step(1'b1, 8'h42, 1'b0, 1'b0);
        n_checks++; if (o_rd_data !== 8'h42 || o_count !== CW'(1)) begin
            n_errors++; $display("FAIL clr_resume: got data=%h count=%0d want 42/1", o_rd_data, o_count); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, DW'(8'hD0 + i), 1'b0, 1'b0);
        // drop reset between clock edges; the outputs must respond without waiting for an edge
        #2;
        i_rst_n = 1'b0;
        #1;
        n_checks++; if (o_empty !== 1'b1 || o_full !== 1'b0) begin
            n_errors++; $display("FAIL arst_empty_full: got e=%b f=%b want 1/0", o_empty, o_full); end
        n_checks++; if (o_count !== '0) begin n_errors++; $display("FAIL arst_count: got %0d want 0", o_count); end
        n_checks++; if (o_underflow !== 1'b0 || o_rd_data !== '0) begin
            n_errors++; $display("FAIL arst_unf_data: got unf=%b data=%h want 0/00", o_underflow, o_rd_data); end
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        step(1'b1, 8'h9A, 1'b0, 1'b0);
        n_checks++; if (o_rd_data !== 8'h9A || o_count !== CW'(1)) begin
            n_errors++; $display("FAIL arst_resume: got data=%h count=%0d want 9a/1", o_rd_data, o_count); end
    endtask

    initial begin
        test_reset();
        test_push_latency();
        test_fill_overflow();
        test_drain_underflow();
        test_simultaneous();
        test_random_stream();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
